// File: rtl/ram_stream_fifo_ctrl.sv
// Stream FIFO controller around an external single-cycle-latency RAM.
// A 2-entry output buffer absorbs the RAM read latency so m_ready stalls never lose a word.
module ram_stream_fifo_ctrl #(
    parameter int RAM_WIDTH = 8,
    parameter int ADDR_SIZE = 10,
    parameter int RAM_DEPTH = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [RAM_WIDTH-1:0]   s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic [RAM_WIDTH-1:0]   m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   ram_wr_en,
    output logic [ADDR_SIZE-1:0]   ram_wr_add,
    output logic [RAM_WIDTH-1:0]   ram_data_in,
    output logic                   ram_rd_en,
    output logic [ADDR_SIZE-1:0]   ram_rd_add,
    input  logic [RAM_WIDTH-1:0]   ram_data_out,
    output logic [ADDR_SIZE+1:0]   count,
    output logic                   full,
    output logic                   empty
);

    localparam int MW = ADDR_SIZE + 1;
    localparam int CW = ADDR_SIZE + 2;

    logic [ADDR_SIZE-1:0] wr_ptr;
    logic [ADDR_SIZE-1:0] rd_ptr;
    logic [MW-1:0]        mem_count;
    logic                 inflight;
    logic [1:0]           out_count;
    logic [RAM_WIDTH-1:0] buf_head;
    logic [RAM_WIDTH-1:0] buf_tail;
    logic                 wr;
    logic                 rd;
    logic                 pop;
    logic [2:0]           room;

    assign full    = (mem_count == MW'(RAM_DEPTH));
    assign s_ready = !full;
    assign m_valid = (out_count != 2'd0);
    assign m_data  = buf_head;
    assign pop     = m_valid && m_ready;
    assign wr      = s_valid && s_ready && !rst;

    // Free buffer slots once this cycle's pop and the read already in flight are accounted for.
    assign room = 3'd2 - {1'b0, out_count} - {2'b0, inflight} + {2'b0, pop};
    assign rd   = !rst && (mem_count != '0) && (room != 3'd0);

    assign ram_wr_en   = wr;
    assign ram_wr_add  = wr_ptr;
    assign ram_data_in = s_data;
    assign ram_rd_en   = rd;
    assign ram_rd_add  = rd_ptr;

    assign count = CW'(mem_count) + CW'(inflight) + CW'(out_count);
    assign empty = (count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_count <= '0;
            inflight  <= 1'b0;
            out_count <= 2'd0;
        end else begin
            if (wr)
                wr_ptr <= wr_ptr + ADDR_SIZE'(1);
            if (rd)
                rd_ptr <= rd_ptr + ADDR_SIZE'(1);
            case ({wr, rd})
                2'b10:   mem_count <= mem_count + MW'(1);
                2'b01:   mem_count <= mem_count - MW'(1);
                default: mem_count <= mem_count;
            endcase
            inflight  <= rd;
            out_count <= out_count + {1'b0, inflight} - {1'b0, pop};
        end
    end

    // Returning RAM data lands at the tail as seen after this cycle's pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_head <= '0;
        end else if (inflight) begin
            if (pop) begin
                if (out_count == 2'd2) begin
                    buf_head <= buf_tail;
                    buf_tail <= ram_data_out;
                end else begin
                    buf_head <= ram_data_out;
                end
            end else if (out_count == 2'd0) begin
                buf_head <= ram_data_out;
            end else begin
                buf_tail <= ram_data_out;
            end
        end else if (pop) begin
            buf_head <= buf_tail;
        end
    end

endmodule

// File: tb/tb_ram_stream_fifo_ctrl.sv
// Scoreboard bench for ram_stream_fifo_ctrl with a behavioural registered-read RAM.
module tb_ram_stream_fifo_ctrl;

    localparam int W = 8;
    localparam int A = 10;
    localparam int D = 1024;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] s_data;
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_ready;
    logic         ram_wr_en;
    logic [A-1:0] ram_wr_add;
    logic [W-1:0] ram_data_in;
    logic         ram_rd_en;
    logic [A-1:0] ram_rd_add;
    logic [W-1:0] ram_data_out = '0;
    logic [A+1:0] count;
    logic         full;
    logic         empty;

    ram_stream_fifo_ctrl #(.RAM_WIDTH(W), .ADDR_SIZE(A), .RAM_DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .ram_wr_en(ram_wr_en), .ram_wr_add(ram_wr_add), .ram_data_in(ram_data_in),
        .ram_rd_en(ram_rd_en), .ram_rd_add(ram_rd_add), .ram_data_out(ram_data_out),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    logic [W-1:0] ram [0:D-1];
    always @(posedge clk) begin
        if (ram_wr_en) ram[ram_wr_add] <= ram_data_in;
        if (ram_rd_en) ram_data_out <= ram[ram_rd_add];
    end

    int errors = 0;
    int checks = 0;
    int pop_cnt = 0;
    int acc_cnt = 0;
    logic [W-1:0] exp_q[$];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: accepted words enter the queue, presented words are popped and compared.
    logic         stall_prev = 1'b0;
    logic [W-1:0] stall_data = '0;
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_data", m_data, stall_data);
            end
            if (m_valid && m_ready) begin
                pop_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0d expected no word", m_data);
                end else begin
                    chk("order", m_data, exp_q.pop_front());
                end
            end
            stall_prev = m_valid && !m_ready;
            stall_data = m_data;
            if (s_valid && s_ready) begin
                exp_q.push_back(s_data);
                acc_cnt++;
            end
        end
    end

    task automatic send(input logic [W-1:0] d);
        bit ok = 1'b0;
        s_data  = d;
        s_valid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (s_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got s_ready=0 expected 1");
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_empty(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (empty) break;
        end
        chk({name, "_empty"}, empty, 1);
        chk({name, "_queue"}, exp_q.size(), 0);
    endtask

    int n;
    int p0;
    int a0;

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_count", count, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_m_data", m_data, 0);

        // Latency: word visible two edges after the accepting edge
        m_ready = 1'b1;
        s_data  = 8'hA5;
        s_valid = 1'b1;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        chk("lat_edge0", m_valid, 0);
        @(posedge clk);
        #1;
        chk("lat_edge1", m_valid, 0);
        @(posedge clk);
        #1;
        chk("lat_edge2_valid", m_valid, 1);
        chk("lat_edge2_data", m_data, 8'hA5);
        wait_empty("lat", 20);

        // Fill: 1024 in RAM plus 2 in the output buffer
        m_ready = 1'b0;
        for (int i = 0; i < 1026; i++) send(W'(i));
        chk("fill_full", full, 1);
        chk("fill_s_ready", s_ready, 0);
        chk("fill_count", count, 1026);

        // Full boundary: pop while full refuses the write, the next cycle takes it
        s_data  = 8'hEE;
        s_valid = 1'b1;
        m_ready = 1'b1;
        #1;
        chk("bnd_no_accept", s_ready, 0);
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        chk("bnd_ready_next", s_ready, 1);
        chk("bnd_count_1025", count, 1025);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        chk("bnd_count_1026", count, 1026);
        chk("bnd_full_again", full, 1);

        m_ready = 1'b1;
        wait_empty("drain", 1300);

        // Streaming: one accept and one pop per cycle
        p0 = pop_cnt;
        a0 = acc_cnt;
        n  = 0;
        for (int k = 0; k < 3000; k++) begin
            s_data  = W'(n);
            s_valid = 1'b1;
            @(negedge clk);
            if (s_ready) n++;
            @(posedge clk);
            #1;
        end
        chk("stream_accepts", acc_cnt - a0, 3000);
        chk("stream_pops", pop_cnt - p0, 2997);
        s_valid = 1'b0;
        wait_empty("stream", 20);

        // Reset mid-stream with 5 words held
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(W'(8'h10 + i));
        repeat (3) @(posedge clk);
        #1;
        chk("mid_count_5", count, 5);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_m_valid", m_valid, 0);
        chk("mid_rst_s_ready", s_ready, 1);
        m_ready = 1'b1;
        s_data  = 8'h3C;
        s_valid = 1'b1;
        #1;
        chk("mid_wr_en", ram_wr_en, 1);
        chk("mid_wr_add", ram_wr_add, 0);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        wait_empty("mid", 20);

        // Random backpressure
        for (int k = 0; k < 10000; k++) begin
            @(posedge clk);
            #1;
            s_valid = 1'($urandom_range(0, 1));
            s_data  = W'($urandom);
            m_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        m_ready = 1'b1;
        wait_empty("rand", 1300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_stream_fifo_ctrl.md
RAM_STREAM_FIFO_CTRL -- requirements
Module: ram_stream_fifo_ctrl

Interface
REQ-001 SHALL have parameter RAM_WIDTH, default 8, data word width.
REQ-002 SHALL have parameter ADDR_SIZE, default 10, RAM address width.
REQ-003 SHALL have parameter RAM_DEPTH, default 1024, RAM words; must equal 2**ADDR_SIZE.
REQ-004 SHALL have port clk, input, 1, clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-006 SHALL have port s_data, input, RAM_WIDTH, write-stream data.
REQ-007 SHALL have port s_valid, input, 1, write-stream valid.
REQ-008 SHALL have port s_ready, output, 1, write-stream ready.
REQ-009 SHALL have port m_data, output, RAM_WIDTH, read-stream data.
REQ-010 SHALL have port m_valid, output, 1, read-stream valid.
REQ-011 SHALL have port m_ready, input, 1, read-stream ready.
REQ-012 SHALL have port ram_wr_en, output, 1, RAM write enable.
REQ-013 SHALL have port ram_wr_add, output, ADDR_SIZE, RAM write address.
REQ-014 SHALL have port ram_data_in, output, RAM_WIDTH, RAM write data.
REQ-015 SHALL have port ram_rd_en, output, 1, RAM read enable.
REQ-016 SHALL have port ram_rd_add, output, ADDR_SIZE, RAM read address.
REQ-017 SHALL have port ram_data_out, input, RAM_WIDTH, RAM registered read data (1-cycle latency, held when ram_rd_en=0).
REQ-018 SHALL have port count, output, ADDR_SIZE+2, total words held (RAM + in-flight + output buffer).
REQ-019 SHALL have ports full and empty, output, 1 each: full = RAM region holds RAM_DEPTH words; empty = count==0.

Function
REQ-020 SHALL treat a write as accepted in a cycle where s_valid && s_ready; s_ready = !full, from registered state only.
REQ-021 SHALL drive ram_wr_en = s_valid && s_ready, ram_wr_add = wr_ptr, ram_data_in = s_data, combinationally.
REQ-022 SHALL increment wr_ptr and rd_ptr modulo RAM_DEPTH (natural wrap from RAM_DEPTH-1 to 0).
REQ-023 SHALL keep mem_count (0..RAM_DEPTH) = words written but not yet read; +1 on write, -1 on read issue, unchanged on both.
REQ-024 SHALL keep a 2-entry output buffer (out_count 0..2) and a 1-bit inflight flag = ram_rd_en registered.
REQ-025 SHALL assert ram_rd_en, ram_rd_add = rd_ptr, when mem_count!=0 and (2 - out_count - inflight + pop) > 0, pop = m_valid && m_ready.
REQ-026 SHALL capture ram_data_out into the output buffer tail on the edge where inflight=1.
REQ-027 SHALL present buffer head on m_data; m_valid = out_count!=0; pop removes head.
REQ-028 SHALL hold m_data stable while m_valid && !m_ready.
REQ-029 SHALL deliver words in acceptance order, no loss or duplication.
REQ-030 SHALL raise m_valid, from empty, on the second rising edge after the edge that accepts a word.
REQ-031 SHALL sustain one accept and one pop per cycle with m_ready held high.
REQ-032 SHALL never issue a read to the address written in the same cycle (guaranteed by REQ-025 using registered mem_count).
REQ-033 SHALL, when full and pop occurs, not accept in that cycle; s_ready rises the cycle after a read issue frees a RAM word.
REQ-034 SHALL drive count = mem_count + inflight + out_count; maximum RAM_DEPTH+2.

Reset
REQ-035 SHALL on rst=1 at a clock edge clear wr_ptr, rd_ptr, mem_count, inflight, out_count; outputs then: m_valid=0, empty=1, full=0, count=0, s_ready=1, m_data=0.
REQ-036 SHALL force ram_wr_en=0 and ram_rd_en=0 while rst=1; an in-flight read at reset is discarded.
REQ-037 SHALL leave RAM contents undefined after reset; only new writes are read.

Verification
REQ-038 Reset: assert rst 2 cycles mid-stream with 5 words held -> count=0, m_valid=0, s_ready=1; next word written to address 0 emerges first.
REQ-039 Latency: write 0xA5 into empty block, m_ready=1 -> m_valid=1, m_data=0xA5 two edges after acceptance edge.
REQ-040 Fill: m_ready=0, write 1026 words 0..1025 (mod 256) -> full=1, s_ready=0, count=1026; then drain -> exact order, empty=1.
REQ-041 Streaming: s_valid=1, m_ready=1 for 3000 cycles -> one word per cycle after fill latency, pointers wrap past 1023 without error.
REQ-042 Backpressure: random m_ready and s_valid, 10000 cycles -> scoreboard order match, m_data stable while stalled.
REQ-043 Full boundary: at full, s_valid=1 and pop -> no accept that cycle, accept next cycle, count stays 1025-1026.
